// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD complementer: digit constants and FSM encoding.
package bcd_pkg;

    localparam int unsigned BCD_W    = 4;
    localparam logic [3:0]  BCD_NINE = 4'd9;
    localparam logic [4:0]  BCD_TEN  = 5'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_cmpl.sv
// Combinational single-digit BCD complement: q = (9 - d) + cin, folded to 0 with carry at ten.
module bcd_digit_cmpl
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] d,
    input  logic             cin,
    output logic [BCD_W-1:0] q,
    output logic             cout,
    output logic             bad
);

    logic [BCD_W-1:0] w_d_eff;
    logic [4:0]       w_sum;

    always_comb begin
        bad     = (d > BCD_NINE);
        // Out-of-range digits behave as 9 so the 9's result digit is 0.
        w_d_eff = bad ? BCD_NINE : d;
        w_sum   = {1'b0, BCD_NINE - w_d_eff} + {4'b0000, cin};
        if (w_sum == BCD_TEN) begin
            q    = '0;
            cout = 1'b1;
        end else begin
            q    = w_sum[BCD_W-1:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_cmpl_seq.sv
// Serial NDIG-digit BCD 9's/10's complementer, one digit per clock, LSD first.
// Define BCD_CMPL_ERR_EN to add err_o, a per-transaction sticky invalid-digit flag.
module bcd_cmpl_seq
    import bcd_pkg::*;
#(
    parameter int unsigned NDIG = 4,
    parameter int unsigned CNTW = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BCD_W*NDIG-1:0] code_i,
    input  logic                  mode_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BCD_W*NDIG-1:0] out_o,
`ifdef BCD_CMPL_ERR_EN
    output logic                  err_o,
`endif
    output logic                  cout_o
);

    state_t                r_state;
    state_t                w_state_d;
    logic [CNTW-1:0]       r_idx;
    logic [BCD_W*NDIG-1:0] r_code;
    logic [BCD_W*NDIG-1:0] r_out;
    logic                  r_carry;
    logic                  r_cout;
    logic [BCD_W-1:0]      w_digit;
    logic [BCD_W-1:0]      w_q;
    logic                  w_cout;
    logic                  w_bad;
    logic                  w_last;
    logic                  w_accept;

    assign w_digit  = r_code[r_idx*BCD_W +: BCD_W];
    assign w_last   = (r_idx == CNTW'(NDIG - 1));
    assign w_accept = in_valid && (r_state == S_IDLE);

    bcd_digit_cmpl u_digit (
        .d    (w_digit),
        .cin  (r_carry),
        .q    (w_q),
        .cout (w_cout),
        .bad  (w_bad)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_d = S_BUSY;
            end
            S_BUSY: begin
                if (w_last) w_state_d = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_d = S_IDLE;
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx   <= '0;
            r_code  <= '0;
            r_out   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= '0;
            r_code  <= code_i;
            r_out   <= '0;
            r_carry <= mode_i;
            r_cout  <= 1'b0;
        end else if (r_state == S_BUSY) begin
            r_out[r_idx*BCD_W +: BCD_W] <= w_q;
            r_carry                     <= w_cout;
            // Hold idx on the last digit instead of relying on counter overflow.
            if (w_last) begin
                r_cout <= w_cout;
            end else begin
                r_idx  <= r_idx + 1'b1;
            end
        end
    end

`ifdef BCD_CMPL_ERR_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (reset || w_accept) begin
            r_err <= 1'b0;
        end else if (r_state == S_BUSY) begin
            r_err <= r_err | w_bad;
        end
    end

    assign err_o = r_err;
`endif

    assign out_o  = r_out;
    assign cout_o = r_cout;

endmodule
